// File: rtl/ysyx_24080006_pkg.sv
// Shared types and constants for the ysyx_24080006 core.
// Contents:
//   IbufDepth    - default instruction buffer depth
//   NopInst      - instruction shown in place of a faulted fetch (addi x0,x0,0)
//   ibuf_entry_t - one buffered fetch beat {pc, inst, err}
package ysyx_24080006_pkg;

  localparam int unsigned IbufDepth = 4;
  localparam logic [31:0] NopInst   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ibuf_entry_t;

endpackage

// File: rtl/ysyx_24080006_ibuf_ram.sv
// Register-array storage for the instruction buffer. No reset on the array.
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write index
//   wdata_i - write data
//   raddr_i - asynchronous read index
//   rdata_o - asynchronous read data
module ysyx_24080006_ibuf_ram #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 65,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_24080006_ibuf.sv
// Instruction buffer between IFU and ID: a circular FIFO of fetch beats with
// valid/ready handshakes on both sides and a flush for pipeline redirects.
// Build option: YSYX_24080006_IBUF_BYPASS_EN - when defined, a beat arriving
// at an empty buffer is presented on out_* in the same cycle.
// Ports:
//   clock, reset_n           - clock, asynchronous active-low reset
//   flush_i                  - drop all buffered entries (and any push this cycle)
//   in_valid_i / in_ready_o  - IFU handshake; in_pc_i, in_inst_i, in_err_i beat data
//   out_valid_o / out_ready_i - ID handshake; out_pc_o, out_inst_o, out_err_o head data
//   count_o                  - number of occupied entries
module ysyx_24080006_ibuf
  import ysyx_24080006_pkg::*;
#(
  parameter int unsigned Depth = IbufDepth,
  localparam int unsigned PtrW = $clog2(Depth) + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_pc_i,
  input  logic [31:0]     in_inst_i,
  input  logic            in_err_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_pc_o,
  output logic [31:0]     out_inst_o,
  output logic            out_err_o,
  output logic [PtrW-1:0] count_o
);

  localparam int unsigned IdxW = $clog2(Depth);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            empty, full;
  logic            push, pop, ram_we;
  logic            bypass, bypass_take;
  ibuf_entry_t     in_entry, rd_entry, head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                 (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);

  // Registered state only, so there is no combinational IFU->ID path.
  assign in_ready_o = !full;
  assign push       = in_valid_i & in_ready_o;

`ifdef YSYX_24080006_IBUF_BYPASS_EN
  assign bypass = empty & in_valid_i & !flush_i;
`else
  assign bypass = 1'b0;
`endif
  // A bypassed beat consumed this cycle never lands in storage.
  assign bypass_take = bypass & out_ready_i;

  assign pop    = !empty & out_ready_i;
  assign ram_we = push & !flush_i & !bypass_take;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (ram_we) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign in_entry = '{pc: in_pc_i, inst: in_inst_i, err: in_err_i};

  ysyx_24080006_ibuf_ram #(
    .Depth (Depth),
    .Width ($bits(ibuf_entry_t))
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[IdxW-1:0]),
    .wdata_i (in_entry),
    .raddr_i (rd_ptr_q[IdxW-1:0]),
    .rdata_o (rd_entry)
  );

  assign head        = bypass ? in_entry : rd_entry;
  assign out_valid_o = !empty | bypass;
  assign count_o     = wr_ptr_q - rd_ptr_q;

  // Zero data when idle; a faulted fetch shows a NOP but keeps its pc for mepc.
  always_comb begin
    out_pc_o   = '0;
    out_inst_o = '0;
    out_err_o  = 1'b0;
    if (out_valid_o) begin
      out_pc_o   = head.pc;
      out_inst_o = head.err ? NopInst : head.inst;
      out_err_o  = head.err;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_ibuf.sv
module tb_ysyx_24080006_ibuf;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_pc_i = '0;
  logic [31:0] in_inst_i = '0;
  logic        in_err_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic        out_err_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_24080006_ibuf #(.Depth(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_pc_i     (in_pc_i),
    .in_inst_i   (in_inst_i),
    .in_err_i    (in_err_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_pc_o    (out_pc_o),
    .out_inst_o  (out_inst_o),
    .out_err_o   (out_err_o),
    .count_o     (count_o)
  );

  typedef struct {
    string       name;
    logic        flush;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    logic        out_ready;
    logic        ev;
    logic        er;
    logic [2:0]  ec;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        eerr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic ev, input logic er,
                           input logic [2:0] ec, input logic [31:0] epc,
                           input logic [31:0] einst, input logic eerr);
    chk({name, ".out_valid"}, {31'd0, out_valid_o}, {31'd0, ev});
    chk({name, ".in_ready"},  {31'd0, in_ready_o},  {31'd0, er});
    chk({name, ".count"},     {29'd0, count_o},     {29'd0, ec});
    chk({name, ".out_pc"},    out_pc_o,             epc);
    chk({name, ".out_inst"},  out_inst_o,           einst);
    chk({name, ".out_err"},   {31'd0, out_err_o},   {31'd0, eerr});
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic err, input logic ordy);
    flush_i     = fl;
    in_valid_i  = iv;
    in_pc_i     = pc;
    in_inst_i   = inst;
    in_err_i    = err;
    out_ready_i = ordy;
  endtask

  // Advance one edge, then idle the inputs so outputs reflect stored state only.
  task automatic step();
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    // Fill, hold off a fifth beat, pop while full, then drain to empty.
    vecs[0] = '{"fill0", 0, 1, 32'h8000_0000, 32'h0010_0093, 0, 0,
                1, 1, 3'd1, 32'h8000_0000, 32'h0010_0093, 0};
    vecs[1] = '{"fill1", 0, 1, 32'h8000_0004, 32'h0020_0113, 0, 0,
                1, 1, 3'd2, 32'h8000_0000, 32'h0010_0093, 0};
    vecs[2] = '{"fill2", 0, 1, 32'h8000_0008, 32'h0030_0193, 0, 0,
                1, 1, 3'd3, 32'h8000_0000, 32'h0010_0093, 0};
    vecs[3] = '{"fill3", 0, 1, 32'h8000_000C, 32'h0040_0213, 0, 0,
                1, 0, 3'd4, 32'h8000_0000, 32'h0010_0093, 0};
    vecs[4] = '{"held5", 0, 1, 32'h8000_0010, 32'h0050_0293, 0, 0,
                1, 0, 3'd4, 32'h8000_0000, 32'h0010_0093, 0};
    vecs[5] = '{"fullpop", 0, 1, 32'h8000_0010, 32'h0050_0293, 0, 1,
                1, 1, 3'd3, 32'h8000_0004, 32'h0020_0113, 0};
    vecs[6] = '{"drain1", 0, 0, 32'h0, 32'h0, 0, 1,
                1, 1, 3'd2, 32'h8000_0008, 32'h0030_0193, 0};
    vecs[7] = '{"drain2", 0, 0, 32'h0, 32'h0, 0, 1,
                1, 1, 3'd1, 32'h8000_000C, 32'h0040_0213, 0};
    vecs[8] = '{"drain3", 0, 0, 32'h0, 32'h0, 0, 1,
                0, 1, 3'd0, 32'h0, 32'h0, 0};

    // Reset then idle.
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_out("reset", 0, 1, 3'd0, 32'h0, 32'h0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].pc, vecs[i].inst, vecs[i].err,
            vecs[i].out_ready);
      step();
      check_out(vecs[i].name, vecs[i].ev, vecs[i].er, vecs[i].ec, vecs[i].epc,
                vecs[i].einst, vecs[i].eerr);
    end

    // Streaming push/pop for 10 beats; pointers wrap past index 3.
    for (int k = 0; k < 10; k++) begin
      logic [31:0] pc;
      logic [31:0] inst;
      pc   = 32'h8000_0020 + 32'(4 * k);
      inst = 32'h0000_0093 | (32'(k) << 20);
      drive(1'b0, 1'b1, pc, inst, 1'b0, (k != 0));
      step();
      check_out($sformatf("stream%0d", k), 1, 1, 3'd1, pc, inst, 0);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    check_out("stream_end", 0, 1, 3'd0, 32'h0, 32'h0, 0);

    // Flush with a concurrent push and pop.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'h8000_0300 + 32'(4 * k), 32'h0010_0093, 1'b0, 1'b0);
      step();
    end
    check_out("flush_fill", 1, 1, 3'd3, 32'h8000_0300, 32'h0010_0093, 0);
    drive(1'b1, 1'b1, 32'h8000_0100, 32'h0070_0393, 1'b0, 1'b1);
    #1;
    chk("flush_pre_valid", {31'd0, out_valid_o}, 32'd1);
    step();
    check_out("flush", 0, 1, 3'd0, 32'h0, 32'h0, 0);
    step();
    check_out("flush_after", 0, 1, 3'd0, 32'h0, 32'h0, 0);

    // Fetch fault through storage.
    drive(1'b0, 1'b1, 32'h8000_0200, 32'hFFFF_FFFF, 1'b1, 1'b0);
    #1;
`ifdef YSYX_24080006_IBUF_BYPASS_EN
    chk("err_pre_valid", {31'd0, out_valid_o}, 32'd1);
`else
    chk("err_pre_valid", {31'd0, out_valid_o}, 32'd0);
`endif
    step();
    check_out("err", 1, 1, 3'd1, 32'h8000_0200, 32'h0000_0013, 1);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    check_out("err_pop", 0, 1, 3'd0, 32'h0, 32'h0, 0);

    // Fault beat into an empty buffer with the consumer ready.
    drive(1'b0, 1'b1, 32'h8000_0200, 32'hFFFF_FFFF, 1'b1, 1'b1);
    #1;
`ifdef YSYX_24080006_IBUF_BYPASS_EN
    check_out("bypass_same", 1, 1, 3'd0, 32'h8000_0200, 32'h0000_0013, 1);
    step();
    check_out("bypass_after", 0, 1, 3'd0, 32'h0, 32'h0, 0);
`else
    check_out("nobypass_same", 0, 1, 3'd0, 32'h0, 32'h0, 0);
    step();
    check_out("nobypass_after", 1, 1, 3'd1, 32'h8000_0200, 32'h0000_0013, 1);
`endif

    // Asynchronous reset mid-operation.
    drive(1'b0, 1'b1, 32'h8000_0400, 32'h0010_0093, 1'b0, 1'b0);
    step();
    #2 reset_n = 1'b0;
    #1;
    check_out("async_rst", 0, 1, 3'd0, 32'h0, 32'h0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check_out("post_rst", 0, 1, 3'd0, 32'h0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_ibuf.md
Name: ysyx_24080006_ibuf

Overview:
- Instruction buffer on the producer side of the decoder's instruction input.
- Accepts fetched {pc, inst, fetch-error} beats from the IFU through a valid/ready handshake and stores them in a circular FIFO.
- Presents the oldest entry to the ID stage through a second valid/ready handshake.
- Decouples fetch latency from decode back-pressure; a pipeline redirect (branch, mret, ecall, fence.i) flushes all buffered entries.

Parameters:
- Depth, 4, number of entries; power of two, 2 to 16.
- PtrW, $clog2(Depth)+1, pointer width including the wrap bit; derived, not overridden.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all entries this cycle (redirect).
- in_valid_i  in  1  IFU beat valid.
- in_ready_o  out  1  buffer can accept a beat.
- in_pc_i  in  32  PC of the fetched instruction.
- in_inst_i  in  32  fetched instruction word.
- in_err_i  in  1  fetch access fault for this beat.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  ID stage consumes the head.
- out_pc_o  out  32  head PC.
- out_inst_o  out  32  head instruction.
- out_err_o  out  1  head fetch fault.
- count_o  out  PtrW  number of occupied entries, 0 to Depth.

Behaviour:
- Reset (reset_n low, asynchronous)
  - wr_ptr = rd_ptr = 0, count_o = 0, out_valid_o = 0, in_ready_o = 1.
  - Storage array is not reset.
- Handshakes
  - Push when in_valid_i & in_ready_o.
  - Pop when out_valid_o & out_ready_i.
- Pointers
  - PtrW bits wide; index = low $clog2(Depth) bits.
  - Empty: wr_ptr == rd_ptr.
  - Full: indices equal and MSBs differ.
  - Increments wrap naturally modulo 2^PtrW.
- Flags and count
  - in_ready_o = !full. It depends only on registered state, never on out_ready_i, so there is no combinational path IFU->ID.
  - out_valid_o = !empty.
  - count_o = wr_ptr - rd_ptr, PtrW-bit modular subtraction.
- Latency: a beat pushed in cycle N is visible at the outputs in cycle N+1 (registered storage, no bypass; see Optional Feature).
- Simultaneous push and pop
  - Allowed when neither full nor empty; count unchanged.
  - When full, push is blocked (in_ready_o=0); the pop still completes, and in_ready_o rises the next cycle.
  - When empty, pop cannot occur (out_valid_o=0).
- Output data
  - When out_valid_o=0: out_pc_o, out_inst_o and out_err_o are driven to 0, so the decoder sees opcode 0 and flags inst_err. That is harmless because valid is low.
  - When out_err_o=1: out_inst_o is forced to 32'h00000013 (addi x0,x0,0) and out_pc_o is kept for mepc.
- Flush
  - flush_i=1 sets rd_ptr <= wr_ptr at the next edge (empty); a push in the same cycle is dropped.
  - A pop in the same cycle is ignored.
  - While flush_i=1, out_valid_o still reflects the pre-flush state; the consumer ignores it during redirect.
- Reset mid-operation: all entries lost immediately; outputs return to their reset values asynchronously.
- No internal state machine beyond the pointer pair.

Optional Feature:
- Macro: YSYX_24080006_IBUF_BYPASS_EN.
- Defined:
  - When empty and in_valid_i=1, the input beat appears combinationally on out_* with out_valid_o=1 in the same cycle.
  - If out_ready_i=1 that cycle, the beat is consumed and not written (pointers unchanged).
  - Otherwise it is written normally.
  - in_ready_o is unchanged by bypass.
  - flush_i suppresses bypass (out_valid_o=0 when flush_i=1 and empty).
- Undefined: one-cycle minimum latency as described in Behaviour.

Decomposition:
- ysyx_24080006_pkg gains:
  - ibuf_entry_t = packed struct {logic [31:0] pc; logic [31:0] inst; logic err;}.
  - IbufDepth = 4.
  - NopInst = 32'h00000013.
- One sub-module, ysyx_24080006_ibuf_ram: Depth x $bits(ibuf_entry_t) register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata), no reset.
- Pointer and flag logic stays in the top.

Test Plan:
- Reset then idle: reset_n low for 3 cycles, release, no stimulus -> out_valid_o=0, in_ready_o=1, count_o=0, out_inst_o=0.
- Fill to full: push pc 0x80000000..0x8000000C (inst 0x00100093, 0x00200113, 0x00300193, 0x00400213) with out_ready_i=0 -> count_o=4, in_ready_o=0. A fifth beat (pc 0x80000010) is held off and not stored.
- Drain in order with wrap: continuous push/pop for 10 beats at pc step 4 -> each out_pc_o equals the input pc one cycle later; count_o stays 1; pointers wrap past index 3 without loss.
- Full with simultaneous pop: full buffer, out_ready_i=1 and in_valid_i=1 -> that cycle's push rejected, head popped, count_o=3 next cycle, in_ready_o=1.
- Flush with concurrent push: 3 entries stored, flush_i=1 with in_valid_i=1 pc 0x80000100 -> next cycle count_o=0, out_valid_o=0; pc 0x80000100 never appears.
- Fetch fault and bypass: push in_err_i=1 pc 0x80000200 inst 0xFFFFFFFF -> out_err_o=1, out_inst_o=0x00000013, out_pc_o=0x80000200. With YSYX_24080006_IBUF_BYPASS_EN defined, empty buffer and out_ready_i=1 -> same values on out_* in the push cycle, count_o stays 0.
